// File: rtl/counter_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl_pkg
// Shared types and helpers for the triangle-sweep controller that drives an
// up/down step counter between programmable bounds.
//   state_e      : controller state (IDLE holds the counter in reset)
//   drive_t      : per-cycle drive decision {down, step, turn}
//   MIN_GAP      : smallest legal distance between the lower and upper bound
//   drive_decide : picks direction and step size from state, value and bounds
// -----------------------------------------------------------------------------
package counter_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  typedef struct packed {
    logic down;  // 1 = decrement this cycle
    logic step;  // 1 = move by 2, 0 = move by 1
    logic turn;  // direction reverses at the coming edge
  } drive_t;

  localparam int unsigned MIN_GAP = 2;

  // Operands arrive zero-extended to 32 bits, so every distance below is
  // computed with headroom above the counter width and cannot wrap. The
  // subtractions are only evaluated on the side of the comparison where the
  // minuend is the larger value.
  function automatic drive_t drive_decide(input state_e      st,
                                          input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
    drive_t d;
    d = '0;
    case (st)
      ST_UP: begin
        if (v < hi) begin
          d.step = ((hi - v) >= MIN_GAP);
        end else begin
          // At or above the top bound: already head down this cycle so the
          // bound value is occupied for exactly one cycle.
          d.turn = 1'b1;
          d.down = 1'b1;
          d.step = ((v - lo) >= MIN_GAP);
        end
      end
      ST_DOWN: begin
        if (v > lo) begin
          d.down = 1'b1;
          d.step = ((v - lo) >= MIN_GAP);
        end else begin
          d.turn = 1'b1;
          d.step = ((hi - v) >= MIN_GAP);
        end
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage : counter_sweep_ctrl_pkg

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
// Drives an external up/down step counter so that its value sweeps as a
// triangle wave between an active lower and upper bound. The counter value is
// read back every cycle and direction/step size are chosen so the bounds are
// hit exactly, never overshot. New bounds arrive through a valid/ready
// handshake and take effect in IDLE or at the bottom turnaround.
//
// Ports
//   clk        : clock, rising edge
//   nrst       : asynchronous active-low reset
//   run        : 1 = sweep, 0 = return to IDLE (counter held in reset)
//   cnt_in     : counter value fed back from the counter
//   cfg_valid  : new bounds offered
//   cfg_lo     : requested lower bound
//   cfg_hi     : requested upper bound
//   cfg_ready  : bounds can be accepted
//   cfg_err    : one-cycle pulse, last accepted bounds were illegal
//   cnt_nrst   : counter reset, registered (low exactly while IDLE)
//   cnt_step   : counter step, 1 = move by 2
//   cnt_down   : counter direction, 1 = decrement
//   sweep_done : one-cycle pulse after each DOWN->UP turnaround
//   sweeps     : completed-sweep count, wraps
// -----------------------------------------------------------------------------
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         run,
  input  logic [N-1:0] cnt_in,
  input  logic         cfg_valid,
  input  logic [N-1:0] cfg_lo,
  input  logic [N-1:0] cfg_hi,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         cnt_nrst,
  output logic         cnt_step,
  output logic         cnt_down,
  output logic         sweep_done,
  output logic [W-1:0] sweeps
);

  localparam logic [N:0]   GAP_EXT = (N+1)'(MIN_GAP);
  localparam logic [N-1:0] HI_RST  = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic         pend_q, pend_d;          // legal bounds waiting to be applied
  logic [N-1:0] pend_lo_q, pend_lo_d;
  logic [N-1:0] pend_hi_q, pend_hi_d;
  logic         err_pend_q, err_pend_d;  // illegal bounds taken, error due
  logic         cfg_err_q, cfg_err_d;
  logic         done_q, done_d;
  logic [W-1:0] sweeps_q, sweeps_d;
  logic         cnt_nrst_q, cnt_nrst_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  drive_t drv;
  logic   turn_up;
  logic   cfg_fire;
  logic   cfg_legal;
  logic   apply;

  assign drv       = drive_decide(state_q, 32'(cnt_in), 32'(lo_q), 32'(hi_q));
  assign turn_up   = (state_q == ST_DOWN) && drv.turn;
  assign cfg_ready = ~(pend_q | err_pend_q);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_legal = ({1'b0, cfg_hi} >= ({1'b0, cfg_lo} + GAP_EXT));
  // Pending bounds only switch in while the counter is parked or at the
  // bottom turnaround; the turnaround cycle itself still uses the old bounds.
  assign apply     = pend_q && ((state_q == ST_IDLE) || turn_up);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    pend_d     = pend_q;
    pend_lo_d  = pend_lo_q;
    pend_hi_d  = pend_hi_q;
    err_pend_d = 1'b0;
    cfg_err_d  = err_pend_q;
    done_d     = turn_up;
    sweeps_d   = turn_up ? (sweeps_q + W'(1)) : sweeps_q;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_UP;
      end
      ST_UP, ST_DOWN: begin
        // Dropping run wins over a turnaround; the sweep count above still
        // records the completed sweep.
        if (!run)          state_d = ST_IDLE;
        else if (drv.turn) state_d = (state_q == ST_UP) ? ST_DOWN : ST_UP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      lo_d   = pend_lo_q;
      hi_d   = pend_hi_q;
      pend_d = 1'b0;
    end

    // A transfer can only happen while nothing is pending, so it never
    // collides with the apply above.
    if (cfg_fire) begin
      if (cfg_legal) begin
        pend_d    = 1'b1;
        pend_lo_d = cfg_lo;
        pend_hi_d = cfg_hi;
      end else begin
        err_pend_d = 1'b1;
      end
    end

    cnt_nrst_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      lo_q       <= '0;
      hi_q       <= HI_RST;
      pend_q     <= 1'b0;
      pend_lo_q  <= '0;
      pend_hi_q  <= '0;
      err_pend_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
      sweeps_q   <= '0;
      cnt_nrst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      pend_q     <= pend_d;
      pend_lo_q  <= pend_lo_d;
      pend_hi_q  <= pend_hi_d;
      err_pend_q <= err_pend_d;
      cfg_err_q  <= cfg_err_d;
      done_q     <= done_d;
      sweeps_q   <= sweeps_d;
      cnt_nrst_q <= cnt_nrst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cnt_nrst   = cnt_nrst_q;
  assign cnt_step   = drv.step;
  assign cnt_down   = drv.down;
  assign cfg_err    = cfg_err_q;
  assign sweep_done = done_q;
  assign sweeps     = sweeps_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_idle_quiet : assert property (@(posedge clk) disable iff (!nrst)
    (state_q == ST_IDLE) |-> (!cnt_step && !cnt_down));

  a_nrst_tracks_state : assert property (@(posedge clk) disable iff (!nrst)
    cnt_nrst == (state_q != ST_IDLE));

  a_bounds_legal : assert property (@(posedge clk) disable iff (!nrst)
    ({1'b0, hi_q} >= ({1'b0, lo_q} + GAP_EXT)));

endmodule : counter_sweep_ctrl
